// File: rtl/pipe_pkg.sv
// Shared MEM/WB payload layout and control widths, so every pipeline stage
// packs and unpacks the same bit positions.
package pipe_pkg;

  localparam int ALU_W  = 8;
  localparam int MEM_W  = 8;
  localparam int RD_W   = 3;
  localparam int FLAG_W = 4;

  localparam int FLAG_LSB = 0;
  localparam int RD_LSB   = FLAG_LSB + FLAG_W;
  localparam int MEM_LSB  = RD_LSB + RD_W;
  localparam int ALU_LSB  = MEM_LSB + MEM_W;

  localparam int PIPE_DATA_W = ALU_W + MEM_W + RD_W + FLAG_W;

  localparam int VALID_W   = 1;
  localparam int OCC_W     = 2;
  localparam int STAT_CNT_W = 16;

  typedef struct packed {
    logic [ALU_W-1:0]  alu_result;
    logic [MEM_W-1:0]  mem_data;
    logic [RD_W-1:0]   rd;
    logic [FLAG_W-1:0] alu_flag;
  } memwb_t;

  function automatic logic [PIPE_DATA_W-1:0] pack_memwb(input memwb_t p);
    return {p.alu_result, p.mem_data, p.rd, p.alu_flag};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clear wins over increment and the count never wraps.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// One-cycle valid/ready pipeline stage. SKID=1 adds a skid entry so in_ready
// comes straight from a flop; SKID=0 is a single register with pass-through ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = STAT_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [OCC_W-1:0]  occupancy
);

  logic              main_valid_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic              skid_valid;
  logic              push;
  logic              pop;

  assign push = in_valid && in_ready;
  assign pop  = main_valid_reg && out_ready;

  if (SKID != 0) begin : g_skid
    logic              skid_valid_reg;
    logic [DATA_W-1:0] skid_data_reg;

    // Ready depends only on the skid flop, never on out_ready.
    assign in_ready   = !skid_valid_reg;
    assign skid_valid = skid_valid_reg;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        main_valid_reg <= 1'b0;
        main_data_reg  <= '0;
        skid_valid_reg <= 1'b0;
        skid_data_reg  <= '0;
      end else if (flush) begin
        main_valid_reg <= 1'b0;
        skid_valid_reg <= 1'b0;
      end else if (!main_valid_reg) begin
        if (push) begin
          main_valid_reg <= 1'b1;
          main_data_reg  <= in_data;
        end
      end else if (!skid_valid_reg) begin
        if (pop && push) begin
          main_data_reg <= in_data;
        end else if (pop) begin
          main_valid_reg <= 1'b0;
        end else if (push) begin
          skid_valid_reg <= 1'b1;
          skid_data_reg  <= in_data;
        end
      end else if (pop) begin
        main_data_reg  <= skid_data_reg;
        skid_valid_reg <= 1'b0;
      end
    end
  end else begin : g_reg
    assign in_ready   = !main_valid_reg || out_ready;
    assign skid_valid = 1'b0;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        main_valid_reg <= 1'b0;
        main_data_reg  <= '0;
      end else if (flush) begin
        main_valid_reg <= 1'b0;
      end else if (push) begin
        main_valid_reg <= 1'b1;
        main_data_reg  <= in_data;
      end else if (pop) begin
        main_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid};

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (main_valid_reg && !out_ready),
    .clr     (stat_clr),
    .count   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a SKID=1 instance (4-bit stall counter)
// and a SKID=0 instance share clock and reset.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_stat_clr;
  logic [22:0] a_in_data, a_out_data;
  logic [3:0]  a_stall;
  logic [1:0]  a_occ;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_stat_clr;
  logic [22:0] b_in_data, b_out_data;
  logic [15:0] b_stall;
  logic [1:0]  b_occ;

  pipe_stage_skid #(.DATA_W(23), .SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .stat_clr(a_stat_clr), .stall_cnt(a_stall),
    .occupancy(a_occ)
  );

  pipe_stage_skid #(.DATA_W(23), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .stat_clr(b_stat_clr), .stall_cnt(b_stall),
    .occupancy(b_occ)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [22:0] exp_a[$];
  logic [22:0] exp_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: a head transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && !a_flush && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected: got 0x%0h, expected no output", a_out_data);
      end else begin
        logic [22:0] e;
        e = exp_a.pop_front();
        check("a_out_data", {9'd0, a_out_data}, {9'd0, e});
        $display("[TB] a out 0x%0h", a_out_data);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && !b_flush && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected: got 0x%0h, expected no output", b_out_data);
      end else begin
        logic [22:0] e;
        e = exp_b.pop_front();
        check("b_out_data", {9'd0, b_out_data}, {9'd0, e});
        $display("[TB] b out 0x%0h", b_out_data);
      end
    end
  end

  // One clock of stimulus; rdy returns in_ready as seen before the edge.
  task automatic step_a(input logic v, input logic [22:0] d, input logic ordy,
                        input logic fl, output logic rdy);
    a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_flush = fl;
    @(negedge clk);
    rdy = a_in_ready;
    if (!reset_n || fl) exp_a.delete();
    else if (v && a_in_ready) exp_a.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, input logic [22:0] d, input logic ordy,
                        input logic fl, output logic rdy);
    b_in_valid = v; b_in_data = d; b_out_ready = ordy; b_flush = fl;
    @(negedge clk);
    rdy = b_in_ready;
    if (!reset_n || fl) exp_b.delete();
    else if (v && b_in_ready) exp_b.push_back(d);
    @(posedge clk); #1;
  endtask

  initial begin
    logic r;
    reset_n = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_flush = 0; a_out_ready = 0; a_stat_clr = 0;
    b_in_valid = 0; b_in_data = '0; b_flush = 0; b_out_ready = 0; b_stat_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_out_valid", {31'd0, a_out_valid}, 0);
    check("rst_a_occ", {30'd0, a_occ}, 0);
    check("rst_a_out_data", {9'd0, a_out_data}, 0);
    check("rst_a_stall", {28'd0, a_stall}, 0);
    check("rst_a_in_ready", {31'd0, a_in_ready}, 1);
    check("rst_b_in_ready", {31'd0, b_in_ready}, 1);
    check("rst_b_out_valid", {31'd0, b_out_valid}, 0);
    reset_n = 1'b1;

    // Basic transfer, one-cycle latency, push+pop keeps occupancy 1
    for (int i = 1; i <= 3; i++) begin
      step_a(1'b1, 23'(i), 1'b1, 1'b0, r);
      check("basic_out_data", {9'd0, a_out_data}, 32'(i));
      check("basic_occ", {30'd0, a_occ}, 1);
    end
    step_a(1'b0, '0, 1'b1, 1'b0, r);
    check("basic_occ_empty", {30'd0, a_occ}, 0);
    check("basic_stall", {28'd0, a_stall}, 0);

    // Back-pressure into the skid entry
    step_a(1'b1, 23'h0A, 1'b0, 1'b0, r);
    check("bp_occ1", {30'd0, a_occ}, 1);
    step_a(1'b1, 23'h0B, 1'b0, 1'b0, r);
    check("bp_occ2", {30'd0, a_occ}, 2);
    check("bp_in_ready", {31'd0, a_in_ready}, 0);
    step_a(1'b1, 23'h0C, 1'b0, 1'b0, r);
    check("bp_hold_ready", {31'd0, r}, 0);
    check("bp_hold_occ", {30'd0, a_occ}, 2);
    check("bp_stall", {28'd0, a_stall}, 2);
    step_a(1'b1, 23'h0D, 1'b1, 1'b0, r);
    check("bp_pop_ready", {31'd0, r}, 0);
    check("bp_skid_moved", {9'd0, a_out_data}, 32'h0B);
    check("bp_occ_after_pop", {30'd0, a_occ}, 1);
    step_a(1'b0, '0, 1'b1, 1'b0, r);
    check("bp_drained", {30'd0, a_occ}, 0);
    check("bp_stall_after", {28'd0, a_stall}, 2);

    // Flush with skid full and an input pending
    step_a(1'b1, 23'h0A, 1'b0, 1'b0, r);
    step_a(1'b1, 23'h0B, 1'b0, 1'b0, r);
    step_a(1'b1, 23'h0C, 1'b0, 1'b1, r);
    check("flush_out_valid", {31'd0, a_out_valid}, 0);
    check("flush_occ", {30'd0, a_occ}, 0);
    step_a(1'b1, 23'h0E, 1'b0, 1'b0, r);
    step_a(1'b1, 23'h0F, 1'b1, 1'b1, r);
    check("flush_accept_occ", {30'd0, a_occ}, 0);
    step_a(1'b0, '0, 1'b1, 1'b0, r);
    check("flush_stall_kept", {28'd0, a_stall}, 4);

    // Stall counter saturation and clear
    a_stat_clr = 1'b1;
    step_a(1'b0, '0, 1'b1, 1'b0, r);
    a_stat_clr = 1'b0;
    check("clr_stall", {28'd0, a_stall}, 0);
    step_a(1'b1, 23'h55, 1'b0, 1'b0, r);
    for (int i = 0; i < 14; i++) step_a(1'b0, '0, 1'b0, 1'b0, r);
    check("sat_stall_14", {28'd0, a_stall}, 14);
    for (int i = 0; i < 6; i++) step_a(1'b0, '0, 1'b0, 1'b0, r);
    check("sat_stall_15", {28'd0, a_stall}, 15);
    a_stat_clr = 1'b1;
    step_a(1'b0, '0, 1'b0, 1'b0, r);
    a_stat_clr = 1'b0;
    check("sat_clr", {28'd0, a_stall}, 0);
    step_a(1'b0, '0, 1'b1, 1'b0, r);
    check("sat_drained", {30'd0, a_occ}, 0);

    // SKID=0 streaming replace
    for (int i = 16; i < 32; i++) begin
      step_b(1'b1, 23'(i), 1'b1, 1'b0, r);
      check("b_stream_ready", {31'd0, r}, 1);
      check("b_stream_occ", {30'd0, b_occ}, 1);
    end
    step_b(1'b1, 23'h20, 1'b0, 1'b0, r);
    check("b_block_ready", {31'd0, r}, 0);
    check("b_block_hold", {9'd0, b_out_data}, 32'h1F);
    step_b(1'b1, 23'h20, 1'b1, 1'b0, r);
    check("b_replace_ready", {31'd0, r}, 1);
    check("b_replace_data", {9'd0, b_out_data}, 32'h20);
    step_b(1'b0, '0, 1'b1, 1'b0, r);
    check("b_drained", {30'd0, b_occ}, 0);

    // Reset mid-stream with both entries held
    step_a(1'b1, 23'h31, 1'b0, 1'b0, r);
    step_a(1'b1, 23'h32, 1'b0, 1'b0, r);
    check("mid_occ2", {30'd0, a_occ}, 2);
    reset_n = 1'b0;
    step_a(1'b1, 23'h33, 1'b1, 1'b0, r);
    check("mid_rst_valid", {31'd0, a_out_valid}, 0);
    check("mid_rst_occ", {30'd0, a_occ}, 0);
    check("mid_rst_data", {9'd0, a_out_data}, 0);
    check("mid_rst_stall", {28'd0, a_stall}, 0);
    check("mid_rst_ready", {31'd0, a_in_ready}, 1);
    reset_n = 1'b1;
    step_a(1'b1, 23'h34, 1'b1, 1'b0, r);
    check("mid_first_data", {9'd0, a_out_data}, 32'h34);
    check("mid_first_valid", {31'd0, a_out_valid}, 1);
    step_a(1'b0, '0, 1'b1, 1'b0, r);
    step_b(1'b0, '0, 1'b1, 1'b0, r);

    check("a_queue_empty", 32'(exp_a.size()), 0);
    check("b_queue_empty", 32'(exp_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
